mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 34 +++
 rtl/mem_responder_mem_array.sv | 58 +++++
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared parameters for the memory responder and the processor-side registers:
// default bus widths, the responder FSM state encoding, the wait-counter width
// and the address range helper used when bounds checking is compiled in.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int DEF_DATA_BUS_WIDTH    = 16;
    localparam int DEF_ADDRESS_BUS_WIDTH = 16;
    localparam int DEF_MEM_DEPTH         = 256;

    // WAIT_CYCLES is limited to 0..15, so four bits hold any load value.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when a word address lies inside a memory of 'depth' words.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input int unsigned depth);
        logic ok_s;
        if (addr < 64'(depth)) begin
            ok_s = 1'b1;
        end else begin
            ok_s = 1'b0;
        end
        return ok_s;
    endfunction

endpackage : mem_responder_pkg

// File: rtl/mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous word array with a write enable and a registered read
// port. The storage itself is never reset; only the read data register is.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset (read data register only)
//   we     - write enable: mem[addr] <= wdata on this edge
//   re     - read enable: rdata <= mem[addr] on this edge
//   clr    - clear rdata to zero on this edge (used when no read data applies)
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data
// -----------------------------------------------------------------------------
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_BUS_WIDTH,
    parameter int DEPTH  = DEF_MEM_DEPTH,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage write port; contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port: load on read, zero on clear, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else if (clr) begin
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule : mem_array

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-mapped responder: accepts one read/write request at a time, waits
// WAIT_CYCLES edges, commits the access to the internal array and holds the
// response until the processor consumes it.
//
// Optional feature (macro MEM_RESPONDER_BOUNDS_CHECK_EN):
//   defined   - addresses >= MEM_DEPTH fault: resp_error=1, write suppressed,
//               resp_rdata=0, same latency.
//   undefined - resp_error is always 0 and the address wraps modulo MEM_DEPTH.
//
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   req_valid    - request present          req_ready  - request can be accepted
//   req_write    - 1 write / 0 read         req_addr   - word address
//   req_wdata    - write data
//   resp_valid   - response available       resp_ready - response consumed
//   resp_rdata   - read data (0 for writes) resp_error - access faulted
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_BUS_WIDTH    = DEF_DATA_BUS_WIDTH,
    parameter int ADDRESS_BUS_WIDTH = DEF_ADDRESS_BUS_WIDTH,
    parameter int MEM_DEPTH         = DEF_MEM_DEPTH,
    parameter int WAIT_CYCLES       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic                         req_write,
    input  logic [ADDRESS_BUS_WIDTH-1:0] req_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    req_wdata,
    output logic                         req_ready,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_BUS_WIDTH-1:0]    resp_rdata,
    output logic                         resp_error
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                         state_r;
    logic [WAIT_CNT_W-1:0]          wait_cnt_r;
    logic                           wr_r;
    logic [ADDRESS_BUS_WIDTH-1:0]   addr_r;
    logic [DATA_BUS_WIDTH-1:0]      wdata_r;
    logic                           req_ready_r;
    logic                           resp_valid_r;
    logic                           resp_error_r;

    logic                           commit_s;
    logic                           addr_ok_s;
    logic                           mem_we_s;
    logic                           mem_re_s;
    logic                           mem_clr_s;
    logic [ADDRESS_BUS_WIDTH+IDX_W-1:0] addr_ext_s;
    logic [IDX_W-1:0]               mem_idx_s;
    logic                           unused_addr_bits_s;

    // Array index is the low address bits; zero-extension keeps the slice
    // legal even when the address bus is narrower than the index.
    always_comb begin
        addr_ext_s = {{IDX_W{1'b0}}, addr_r};
        mem_idx_s  = addr_ext_s[IDX_W-1:0];
    end

    assign unused_addr_bits_s = ^addr_ext_s[ADDRESS_BUS_WIDTH+IDX_W-1:IDX_W];

    // Range qualification of the captured address.
    always_comb begin
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        addr_ok_s = addr_in_range(64'(addr_r), MEM_DEPTH);
`else
        addr_ok_s = 1'b1;
`endif
    end

    // Commit strobes: the access happens on the edge that leaves WAIT, and
    // the read register is cleared whenever that access yields no read data.
    always_comb begin
        if ((state_r == ST_WAIT) && (wait_cnt_r == {WAIT_CNT_W{1'b0}})) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
        mem_we_s  = commit_s & wr_r & addr_ok_s;
        mem_re_s  = commit_s & ~wr_r & addr_ok_s;
        mem_clr_s = commit_s & ~mem_re_s;
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= {WAIT_CNT_W{1'b0}};
            wr_r         <= 1'b0;
            addr_r       <= {ADDRESS_BUS_WIDTH{1'b0}};
            wdata_r      <= {DATA_BUS_WIDTH{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // req_ready_r is 1 throughout IDLE, so req_valid alone accepts.
                    if (req_valid) begin
                        wr_r        <= req_write;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        wait_cnt_r  <= WAIT_LOAD;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (commit_s) begin
                        resp_valid_r <= 1'b1;
                        resp_error_r <= ~addr_ok_s;
                        state_r      <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Consuming the response only re-opens the request port;
                    // the next accept is one edge later.
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    wait_cnt_r   <= {WAIT_CNT_W{1'b0}};
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .DATA_W (DATA_BUS_WIDTH),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .clr   (mem_clr_s),
        .addr  (mem_idx_s),
        .wdata (wdata_r),
        .rdata (resp_rdata)
    );

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_error = resp_error_r;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int WA    = 2;
    localparam int WB    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          a_req_valid, a_req_write, a_req_ready, a_resp_valid, a_resp_ready, a_resp_error;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata, a_resp_rdata;
    logic          b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_ready, b_resp_error;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata, b_resp_rdata;

    mem_responder #(.DATA_BUS_WIDTH(DW), .ADDRESS_BUS_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_ready(a_req_ready),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
        .resp_error(a_resp_error));

    mem_responder #(.DATA_BUS_WIDTH(DW), .ADDRESS_BUS_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WB)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
        .resp_error(b_resp_error));

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model_a [int];
    logic [DW-1:0] model_b [int];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (a_req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", a_req_ready); end
        vectors++; if (a_resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 0", a_resp_valid); end
        vectors++; if (a_resp_rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_resp_rdata: got %h expected 0000", a_resp_rdata); end
        vectors++; if (a_resp_error !== 1'b0) begin miscompares++; $display("FAIL reset_resp_error: got %b expected 0", a_resp_error); end
        vectors++; if (b_req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_b_req_ready: got %b expected 1", b_req_ready); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One complete access on dut_a; inputs are scrambled while it is in flight.
    task automatic access_a(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int hold);
        exp_t e;
        exp_t got_e;
        int   idx;
        int   acc;
        int   budget;
        logic oob;
        logic seen;
        idx = int'(addr) % DEPTH;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        oob = (int'(addr) >= DEPTH);
`else
        oob = 1'b0;
`endif
        if (oob) begin
            e = '{rdata: 16'h0000, err: 1'b1};
        end else if (wr) begin
            e = '{rdata: 16'h0000, err: 1'b0};
            model_a[idx] = wdata;
        end else begin
            e = '{rdata: model_a[idx], err: 1'b0};
        end
        sb_q.push_back(e);
        @(negedge clk);
        budget = 0;
        while (a_req_ready !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
        if (budget >= 20) begin vectors++; miscompares++; $display("FAIL ready_timeout: req_ready stuck at %b expected 1", a_req_ready); end
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata;
        @(posedge clk); #1;
        acc = cyc;
        a_req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            a_req_addr = 16'($urandom); a_req_wdata = 16'($urandom); a_req_write = 1'($urandom);
            vectors++;
            if (a_req_ready !== 1'b0) begin miscompares++; $display("FAIL busy_req_ready: got %b expected 0", a_req_ready); end
            if (a_resp_valid === 1'b1) seen = 1'b1;
        end
        got_e = sb_q.pop_front();
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL resp_timeout: resp_valid %b expected 1 within budget", a_resp_valid);
            return;
        end
        vectors++; if (cyc - acc != WA + 1) begin miscompares++; $display("FAIL latency: got %0d expected %0d", cyc - acc, WA + 1); end
        vectors++; if (a_resp_rdata !== got_e.rdata) begin miscompares++; $display("FAIL resp_rdata: addr %h got %h expected %h", addr, a_resp_rdata, got_e.rdata); end
        vectors++; if (a_resp_error !== got_e.err) begin miscompares++; $display("FAIL resp_error: addr %h got %b expected %b", addr, a_resp_error, got_e.err); end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            vectors++;
            if (a_resp_valid !== 1'b1 || a_resp_rdata !== got_e.rdata) begin
                miscompares++;
                $display("FAIL resp_hold: valid %b data %h expected 1 %h", a_resp_valid, a_resp_rdata, got_e.rdata);
            end
        end
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
        vectors++; if (a_resp_valid !== 1'b0) begin miscompares++; $display("FAIL resp_clear: got %b expected 0", a_resp_valid); end
        vectors++; if (a_req_ready !== 1'b1) begin miscompares++; $display("FAIL idle_req_ready: got %b expected 1", a_req_ready); end
    endtask

    task automatic test_write_read();
        access_a(1'b1, 16'h0005, 16'hBEEF, 0);
        access_a(1'b0, 16'h0005, 16'h0000, 4);
    endtask

    task automatic test_capture();
        access_a(1'b1, 16'h0020, 16'h1357, 0);
        access_a(1'b1, 16'h0021, 16'h2468, 1);
        access_a(1'b0, 16'h0020, 16'h0000, 0);
        access_a(1'b0, 16'h0021, 16'h0000, 2);
    endtask

    task automatic test_reset_abort();
        access_a(1'b1, 16'h0010, 16'h5555, 0);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'h0010; a_req_wdata = 16'h1234;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (a_req_ready !== 1'b1) begin miscompares++; $display("FAIL abort_req_ready: got %b expected 1", a_req_ready); end
        vectors++; if (a_resp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_resp_valid: got %b expected 0", a_resp_valid); end
        vectors++; if (a_resp_rdata !== 16'h0000) begin miscompares++; $display("FAIL abort_resp_rdata: got %h expected 0000", a_resp_rdata); end
        vectors++; if (a_resp_error !== 1'b0) begin miscompares++; $display("FAIL abort_resp_error: got %b expected 0", a_resp_error); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (a_resp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_resp: got %b expected 0", a_resp_valid); end
        end
        access_a(1'b0, 16'h0010, 16'h0000, 0);
    endtask

    task automatic test_bounds();
        access_a(1'b1, 16'h0000, 16'hA5A5, 0);
        access_a(1'b1, 16'h0100, 16'h7777, 0);
        access_a(1'b0, 16'h0000, 16'h0000, 0);
        access_a(1'b0, 16'h00FF, 16'h0000, 0);
    endtask

    // Zero-wait instance, resp_ready held high, req_valid held high.
    task automatic test_back_to_back();
        logic          wr_t [6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0] addr_t [6] = '{16'h0030, 16'h0031, 16'h0032, 16'h0030, 16'h0031, 16'h0032};
        logic [DW-1:0] data_t [6] = '{16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        exp_t e;
        int   acc;
        int   prev;
        int   budget;
        model_b[255] = 16'h0000;
        prev = -1;
        b_resp_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (wr_t[i]) begin
                model_b[int'(addr_t[i])] = data_t[i];
                e = '{rdata: 16'h0000, err: 1'b0};
            end else begin
                e = '{rdata: model_b[int'(addr_t[i])], err: 1'b0};
            end
            sb_q.push_back(e);
            b_req_valid = 1'b1; b_req_write = wr_t[i]; b_req_addr = addr_t[i]; b_req_wdata = data_t[i];
            budget = 0;
            while (b_req_ready !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
            if (budget >= 20) begin vectors++; miscompares++; $display("FAIL b2b_ready_timeout: got %b expected 1", b_req_ready); end
            @(posedge clk); #1;
            acc = cyc;
            if (prev >= 0) begin
                vectors++; if (acc - prev != 3) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 3", acc - prev); end
            end
            prev = acc;
            @(negedge clk);
            vectors++; if (b_resp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_early_resp: got %b expected 0", b_resp_valid); end
            @(negedge clk);
            e = sb_q.pop_front();
            vectors++; if (b_resp_valid !== 1'b1 || cyc - acc != 1) begin miscompares++; $display("FAIL b2b_latency: valid %b after %0d edges expected 1 after 1", b_resp_valid, cyc - acc); end
            vectors++; if (b_resp_rdata !== e.rdata || b_resp_error !== e.err) begin miscompares++; $display("FAIL b2b_rdata: got %h/%b expected %h/%b", b_resp_rdata, b_resp_error, e.rdata, e.err); end
        end
        b_req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 16'h0000; a_req_wdata = 16'h0000; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 16'h0000; b_req_wdata = 16'h0000; b_resp_ready = 1'b0;
        model_a[255] = 16'h0000;
        test_reset();
        access_a(1'b1, 16'h00FF, 16'h0000, 0);
        test_write_read();
        test_capture();
        test_reset_abort();
        test_bounds();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_responder
